// File: rtl/mdu_unit_pkg.sv
// Shared constants and types for the multiply/divide unit: op encoding,
// FSM state codes and default busy durations.
package mdu_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYC = 5;
    localparam int MDU_DIV_CYC  = 10;
    localparam int MDU_CNT_W    = 4;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// Combinational signed/unsigned multiply and divide; the result is captured
// by the FSM at launch and only committed to HI/LO when the busy period ends.
module mdu_calc
    import mdu_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] num_abs;
    logic [31:0] den_abs;
    logic [31:0] quo_abs;
    logic [31:0] rem_abs;
    logic [31:0] den_u;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        rt_zero;

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        rt_zero  = (rt == 32'd0);
        div_zero = is_div(op) && rt_zero;
        // Sign-extended operands give the correct 64-bit signed product.
        prod_s   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u   = {32'd0, rs} * {32'd0, rt};
        // Divide magnitudes, then reapply signs; a zero divisor is replaced
        // by 1 so the datapath never produces X (the result is discarded).
        num_abs  = rs[31] ? -rs : rs;
        den_abs  = rt_zero ? 32'd1 : (rt[31] ? -rt : rt);
        quo_abs  = num_abs / den_abs;
        rem_abs  = num_abs % den_abs;
        den_u    = rt_zero ? 32'd1 : rt;
        quo_u    = rs / den_u;
        rem_u    = rs % den_u;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                res_lo = (rs[31] ^ rt[31]) ? -quo_abs : quo_abs;
                res_hi = rs[31] ? -rem_abs : rem_abs;
            end
            MDU_DIVU: begin
                res_lo = quo_u;
                res_hi = rem_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models multi-cycle busy with a
// down-counter, and commits mult/div results when the busy period ends.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYC,
    parameter int DIV_CYCLES  = MDU_DIV_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mdu_op,
    input  logic        start,
    input  logic        req,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mdu_state_e  state_dbg
);

    mdu_state_e             state, state_nx;
    logic [MDU_CNT_W-1:0]   cnt, cnt_nx;
    logic                   launch, complete, mthi_we, mtlo_we;
    logic [31:0]            res_hi, res_lo, temp_hi, temp_lo;
    logic                   res_dz, temp_dz;

    mdu_calc u_calc (
        .op       (mdu_op),
        .rs       (rs_val),
        .rt       (rt_val),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (res_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MDU_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            busy  <= (state_nx == MDU_RUN);
        end
    end

    // Ops are only accepted in IDLE; anything presented during RUN is dropped.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        launch   = 1'b0;
        complete = 1'b0;
        mthi_we  = 1'b0;
        mtlo_we  = 1'b0;
        case (state)
            MDU_IDLE: begin
                if (!req) begin
                    if (start && is_muldiv(mdu_op)) begin
                        launch   = 1'b1;
                        state_nx = MDU_RUN;
                        cnt_nx   = is_div(mdu_op) ? MDU_CNT_W'(DIV_CYCLES)
                                                  : MDU_CNT_W'(MULT_CYCLES);
                    end else if (mdu_op == MDU_MTHI) begin
                        mthi_we = 1'b1;
                    end else if (mdu_op == MDU_MTLO) begin
                        mtlo_we = 1'b1;
                    end
                end
            end
            MDU_RUN: begin
                if (cnt == MDU_CNT_W'(1)) begin
                    complete = 1'b1;
                    state_nx = MDU_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - MDU_CNT_W'(1);
                end
            end
            default: state_nx = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
            temp_dz <= 1'b0;
        end else begin
            if (launch) begin
                temp_hi <= res_hi;
                temp_lo <= res_lo;
                temp_dz <= res_dz;
            end
            if (complete && !temp_dz) begin
                hi <= temp_hi;
                lo <= temp_lo;
            end
            if (mthi_we) hi <= rs_val;
            if (mtlo_we) lo <= rs_val;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: busy timing, signed/unsigned arithmetic,
// divide-by-zero, MTHI/MTLO, CP0 request and asynchronous reset.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mdu_op;
    logic        start;
    logic        req;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    mdu_state_e  state_dbg;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];

    mdu_unit dut (
        .clk       (clk),
        .reset     (reset),
        .mdu_op    (mdu_op),
        .start     (start),
        .req       (req),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        mdu_op = MDU_NOP;
        start  = 1'b0;
        req    = 1'b0;
        rs_val = 32'd0;
        rt_val = 32'd0;
    endtask

    task automatic drive(input mdu_op_e op, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdu_op = op;
        start  = s;
        rs_val = a;
        rt_val = b;
    endtask

    // Counts negedges with busy high, starting at the first negedge after launch.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b, output int n);
        drive(op, 1'b1, a, b);
        @(negedge clk);
        idle_inputs();
        wait_done(n);
    endtask

    // Scoreboard: pops the expected {hi,lo} for the op just completed.
    task automatic score(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, hi, e[63:32]);
            check({tag, "_lo"}, lo, e[31:0]);
        end
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_state", {31'd0, state_dbg}, {31'd0, MDU_IDLE});
        @(negedge clk);
        reset = 1'b1;

        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, n);
        check("mult_busy_cycles", n, 5);
        score("mult");

        exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        check("multu_busy_cycles", n, 5);
        score("multu");

        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
        check("div_busy_cycles", n, 10);
        score("div_neg");

        drive(MDU_MTHI, 1'b0, 32'h11, 32'd0);
        @(negedge clk);
        idle_inputs();
        check("mthi_11", hi, 32'h11);
        drive(MDU_MTLO, 1'b0, 32'h22, 32'd0);
        @(negedge clk);
        idle_inputs();
        check("mtlo_22", lo, 32'h22);

        exp_q.push_back({32'h11, 32'h22});
        run_op(MDU_DIVU, 32'd7, 32'd0, n);
        check("divu0_busy_cycles", n, 10);
        score("divu_zero");

        exp_q.push_back({32'h0, 32'h8000_0000});
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        score("div_ovf");

        drive(MDU_MTHI, 1'b0, 32'hDEAD_BEEF, 32'd0);
        @(negedge clk);
        idle_inputs();
        check("mthi_dead", hi, 32'hDEAD_BEEF);
        check("mthi_busy", {31'd0, busy}, 32'd0);

        // Launch blocked by a CP0 request
        drive(MDU_MULT, 1'b1, 32'd2, 32'd3);
        req = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("req_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("req_hi", hi, 32'hDEAD_BEEF);
        check("req_lo", lo, 32'h8000_0000);

        // MTLO while busy is dropped
        exp_q.push_back({32'h0, 32'd6});
        drive(MDU_MULT, 1'b1, 32'd2, 32'd3);
        @(negedge clk);
        mdu_op = MDU_MTLO;
        start  = 1'b0;
        rs_val = 32'h55;
        @(negedge clk);
        idle_inputs();
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("mtlo_busy_cycles", n, 5);
        score("mtlo_ignored");

        // Request mid-DIV does not disturb the running op
        exp_q.push_back({32'd2, 32'd14});
        drive(MDU_DIV, 1'b1, 32'd100, 32'd7);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 2;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("div_req_cycles", n, 10);
        score("div_req");

        // Asynchronous reset mid-MULT
        drive(MDU_MULT, 1'b1, 32'd5, 32'd7);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage; executes the MDU_MULT/MULTU/DIV/DIVU/MTHI/MTLO operations issued by the decoder.
- Holds the architectural HI/LO registers, whose values the E-stage AO mux selects for MFHI/MFLO.
- Multi-cycle busy model: the hazard unit stalls D while an MDU-related instruction is in D and (start || busy).
- A CP0 request suppresses issue of the op currently in E.

Parameters:
- MULT_CYCLES, 5, busy duration of MULT/MULTU, in cycles (≥1).
- DIV_CYCLES, 10, busy duration of DIV/DIVU, in cycles (≥1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- mdu_op  in  3  operation code from the decoder (`MDU_* encoding)
- start  in  1  launch of MULT/MULTU/DIV/DIVU, from the decoder's MDU_start
- req  in  1  CP0 exception/interrupt request; the E-stage op is being flushed
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- busy  out  1  registered; high while a mult/div is in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous): busy=0, hi=0, lo=0, counter=0, state=IDLE. Pending results are discarded.
- FSM states: IDLE and RUN. Down-counter cnt is 4 bits wide, sized to hold DIV_CYCLES.
- Issue condition: state==IDLE && !req.
- Any op presented while busy=1 is ignored. The hazard unit guarantees this never happens for legal code.
- Launch:
  - Condition: issue condition, start=1, and mdu_op ∈ {MULT, MULTU, DIV, DIVU}.
  - At edge k, compute the result into temp_hi/temp_lo, load cnt with the op's cycle count, and move to RUN.
  - busy is 1 from edge k through edge k+N−1. At edge k+N, hi/lo are loaded from the temps, busy→0 and state→IDLE.
  - Observed effect: busy high for exactly N cycles; the new hi/lo are visible in the first cycle busy=0.
- Arithmetic:
  - MULT: {hi,lo} = signed(rs)×signed(rt), 64-bit.
  - MULTU: {hi,lo} = unsigned product, 64-bit.
  - DIV: lo = quotient truncated toward zero; hi = remainder, with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Divisor 0 (DIV or DIVU): the op runs its full busy period, but hi/lo keep their prior values.
- MTHI/MTLO:
  - Under the issue condition, mdu_op=MTHI writes hi=rs_val at the next edge; MTLO writes lo=rs_val.
  - No busy cycle; start is 0 for these ops.
- req=1:
  - Suppresses launch and MTHI/MTLO in that cycle; no state change.
  - An op already in RUN is unaffected and completes normally (it was committed before the exception).
- mdu_op=NOP, or start=1 with a non-mult/div code: no effect.
- Back-to-back: a new launch is accepted in the first IDLE cycle after completion. hi/lo update and the new launch occur at separate edges.
- hi/lo are output directly from the registers; no bypass of in-flight results.

Decomposition:
- Shared constants header (the existing constants include):
  - `MDU_NOP=0, `MDU_MULT=1, `MDU_MULTU=2, `MDU_DIV=3, `MDU_DIVU=4, `MDU_MTHI=5, `MDU_MTLO=6.
  - FSM state codes `MDU_IDLE=0, `MDU_RUN=1.
  - Default cycle counts `MDU_MULT_CYC=5, `MDU_DIV_CYC=10.
- One combinational sub-module, mdu_calc, is natural: inputs op, rs, rt; outputs res_hi, res_lo, div_zero. It isolates the signed/unsigned arithmetic from the FSM/counter.

Test Plan:
- Signed multiply:
  - Stimulus: reset released; MULT rs=0xFFFFFFFE (−2), rt=3.
  - Required: busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned multiply:
  - Stimulus: MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF.
  - Required: after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- Divides:
  - DIV rs=−7 (0xFFFFFFF9), rt=2 → busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/0 with prior hi=0x11, lo=0x22 → after 10 cycles hi=0x11, lo=0x22 unchanged.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Move to HI/LO:
  - MTHI rs=0xDEADBEEF → hi=0xDEADBEEF the next cycle; busy stays 0.
  - MTLO issued while busy=1 → lo unchanged.
- Request interaction:
  - MULT with req=1 in the same cycle → busy stays 0 and hi/lo unchanged.
  - req=1 asserted at cycle 2 of a running DIV → the DIV still completes at cycle 10.
- Reset:
  - Drive reset=0 asynchronously mid-MULT (cycle 3) → busy, hi and lo are 0 immediately.
  - After release, no late hi/lo update occurs.
